// File: rtl/bcd_seg_display.sv
// Sequential binary-to-seven-segment driver: double-dabble conversion, one bit per cycle.
// Optional leading-zero blanking is enabled by defining BCD_SEG_LZB_EN.
module bcd_seg_display #(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  hz100,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_value,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [8*DIGITS-1:0]   seg,
  output logic                  ovf,
  output logic                  done
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  function automatic logic [31:0] pow10(input int unsigned n);
    logic [31:0] r;
    r = 32'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

  localparam logic [31:0] LIMIT = pow10(DIGITS);

  function automatic logic [7:0] glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'd0:    g = 8'h3F;
      4'd1:    g = 8'h06;
      4'd2:    g = 8'h5B;
      4'd3:    g = 8'h4F;
      4'd4:    g = 8'h66;
      4'd5:    g = 8'h6D;
      4'd6:    g = 8'h7D;
      4'd7:    g = 8'h07;
      4'd8:    g = 8'h7F;
      4'd9:    g = 8'h6F;
      default: g = 8'h00;
    endcase
    return g;
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t              state, state_next;
  logic [WIDTH-1:0]    sreg;
  logic [BCD_W-1:0]    bcd, bcd_shift;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_next, carry_out;
  logic [8*DIGITS-1:0] seg_next;

  always_ff @(posedge hz100) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT:   if (cnt == CNT_W'(1)) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 and the one-bit left shift are fused per nibble; the top carry is the bit shifted out.
  always_comb begin
    logic [3:0] adj;
    logic       carry;
    bcd_shift = '0;
    carry     = sreg[WIDTH-1];
    for (int unsigned d = 0; d < DIGITS; d++) begin
      adj = bcd[4*d +: 4];
      if (adj >= 4'd5) adj = adj + 4'd3;
      bcd_shift[4*d +: 4] = {adj[2:0], carry};
      carry = adj[3];
    end
    carry_out = carry;
  end

  always_comb begin
    logic [3:0] nib;
    logic [7:0] g;
    logic       higher_zero;
    seg_next    = '0;
    higher_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nib = bcd[4*(DIGITS-1-i) +: 4];
      g   = glyph(nib);
`ifdef BCD_SEG_LZB_EN
      if ((i != DIGITS - 1) && higher_zero && (nib == 4'd0)) g = 8'h00;
`endif
      if (nib != 4'd0) higher_zero = 1'b0;
      seg_next[8*(DIGITS-1-i) +: 8] = ovf_next ? 8'h40 : g;
    end
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      sreg     <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      seg      <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg     <= in_value;
            bcd      <= '0;
            ovf_next <= (32'(in_value) >= LIMIT);
            cnt      <= CNT_W'(WIDTH);
          end
        end
        SHIFT: begin
          bcd  <= bcd_shift;
          sreg <= sreg << 1;
          cnt  <= cnt - CNT_W'(1);
          // A digit lost off the top already implies value >= 10^DIGITS, so this OR never changes ovf.
          ovf_next <= ovf_next | carry_out;
        end
        LOAD: begin
          seg  <= seg_next;
          ovf  <= ovf_next;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
